// File: rtl/upmixer_2b.sv
// Transmit upmixer: I*cos - Q*sin, error-feedback shaped into a 5-level ladder code (0..4).
// Latency 3 edges sin/cos -> RF_code; IQ_ready drops while the 1-entry holding reg is full.
module upmixer_2b #(
  parameter int BITS     = 6,
  parameter int RATE_DIV = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic signed [BITS-1:0] I_in,
  input  logic signed [BITS-1:0] Q_in,
  input  logic                   IQ_valid,
  output logic                   IQ_ready,
  input  logic signed [BITS-1:0] sin_in,
  input  logic signed [BITS-1:0] cos_in,
  output logic [2:0]             RF_code,
  output logic                   RF_out,
  output logic                   UNDERRUN,
  output logic [1:0]             STATE
);

  localparam int CW = $clog2(RATE_DIV);
  localparam int PW = 2 * BITS;
  localparam int SW = PW + 1;
  localparam int EW = PW + 2;
  localparam int VW = PW + 3;
  localparam int SV = 1 << (PW - 2);

  localparam logic signed [VW-1:0] S_P    = VW'(SV);
  localparam logic signed [VW-1:0] S_N    = VW'(-SV);
  localparam logic signed [VW-1:0] OFF_P2 = VW'(2 * SV);
  localparam logic signed [VW-1:0] OFF_N2 = VW'(-2 * SV);
  localparam logic signed [VW-1:0] T_N3   = VW'(-(3 * SV) / 2);
  localparam logic signed [VW-1:0] T_N1   = VW'(-SV / 2);
  localparam logic signed [VW-1:0] T_P1   = VW'(SV / 2);
  localparam logic signed [VW-1:0] T_P3   = VW'((3 * SV) / 2);

  typedef struct packed {
    logic signed [BITS-1:0] i;
    logic signed [BITS-1:0] q;
  } iq_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_UNDER = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   div_cnt;
  logic            hold_full, hold_full_d;
  iq_t             hold_dat, hold_d;
  iq_t             cur_dat, cur_d;
  iq_t             in_dat;
  logic            accept, strobe, under_set;

  logic signed [BITS-1:0] sin_q, cos_q;
  logic signed [PW-1:0]   pi_q, pq_q;
  logic signed [SW-1:0]   s_q;
  logic signed [EW-1:0]   err_q;
  logic signed [VW-1:0]   v, off, e_raw, e_sat;
  logic [2:0]             code_d;

  assign in_dat   = '{i: I_in, q: Q_in};
  assign IQ_ready = !hold_full;
  assign accept   = IQ_valid && IQ_ready;
  assign strobe   = (div_cnt == CW'(RATE_DIV - 1));
  assign STATE    = state_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A strobe with an empty holding reg still counts as served if a sample arrives that cycle.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_dat;
    hold_d      = hold_dat;
    hold_full_d = hold_full;
    under_set   = 1'b0;
    if (!EN) begin
      state_d     = ST_IDLE;
      cur_d       = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_RUN;
        cur_d   = in_dat;
      end
    end else if (strobe) begin
      if (hold_full) begin
        state_d     = ST_RUN;
        cur_d       = hold_dat;
        hold_full_d = 1'b0;
      end else if (accept) begin
        state_d = ST_RUN;
        cur_d   = in_dat;
      end else begin
        state_d   = ST_UNDER;
        cur_d     = '0;
        under_set = 1'b1;
      end
    end else if (accept) begin
      hold_d      = in_dat;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt   <= '0;
      hold_full <= 1'b0;
      hold_dat  <= '0;
      cur_dat   <= '0;
      UNDERRUN  <= 1'b0;
    end else begin
      if (!EN || state_q == ST_IDLE || strobe) div_cnt <= '0;
      else                                     div_cnt <= div_cnt + CW'(1);
      hold_full <= hold_full_d;
      hold_dat  <= hold_d;
      cur_dat   <= cur_d;
      if (under_set) UNDERRUN <= 1'b1;
    end
  end

  always_comb begin
    v      = VW'(s_q) + VW'(err_q);
    code_d = 3'd2;
    off    = '0;
    if (v < T_N3) begin
      code_d = 3'd0;
      off    = OFF_N2;
    end else if (v < T_N1) begin
      code_d = 3'd1;
      off    = S_N;
    end else if (v < T_P1) begin
      code_d = 3'd2;
      off    = '0;
    end else if (v < T_P3) begin
      code_d = 3'd3;
      off    = S_P;
    end else begin
      code_d = 3'd4;
      off    = OFF_P2;
    end
    e_raw = v - off;
    e_sat = e_raw;
    if (e_raw > S_P)      e_sat = S_P;
    else if (e_raw < S_N) e_sat = S_N;
  end

  // Mixer and shaper keep running in IDLE so the residual error drains to mid-scale.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sin_q   <= '0;
      cos_q   <= '0;
      pi_q    <= '0;
      pq_q    <= '0;
      s_q     <= '0;
      err_q   <= '0;
      RF_code <= 3'd2;
      RF_out  <= 1'b1;
    end else begin
      sin_q   <= sin_in;
      cos_q   <= cos_in;
      pi_q    <= PW'($signed(cur_dat.i)) * PW'(cos_q);
      pq_q    <= PW'($signed(cur_dat.q)) * PW'(sin_q);
      s_q     <= SW'(pi_q) - SW'(pq_q);
      err_q   <= EW'(e_sat);
      RF_code <= code_d;
      RF_out  <= (code_d >= 3'd2);
    end
  end

endmodule

// File: tb/tb_upmixer_2b.sv
// Directed and randomized bench for upmixer_2b against an arithmetic reference model.
module tb_upmixer_2b;
  localparam int BITS = 6;
  localparam int RD   = 4;
  localparam int S    = 1 << (2 * BITS - 2);

  logic                   CLK = 1'b0;
  logic                   RST, EN, IQ_valid, IQ_ready;
  logic signed [BITS-1:0] I_in, Q_in, sin_in, cos_in;
  logic [2:0]             RF_code;
  logic                   RF_out, UNDERRUN;
  logic [1:0]             STATE;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  upmixer_2b #(.BITS(BITS), .RATE_DIV(RD)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .I_in(I_in), .Q_in(Q_in), .IQ_valid(IQ_valid), .IQ_ready(IQ_ready),
    .sin_in(sin_in), .cos_in(cos_in),
    .RF_code(RF_code), .RF_out(RF_out), .UNDERRUN(UNDERRUN), .STATE(STATE)
  );

  typedef struct {int i; int q;} smp_t;

  // Model: mixed value per edge, delayed three edges, then round-to-nearest shaping.
  int   mix_q[$];
  smp_t hold_q[$];
  smp_t cur;
  int   m_err, m_code, phase;
  bit   m_run, m_starved, m_underrun;
  bit   pre_acc, pre_rdy;

  function automatic int quant(input int v, output int e);
    int l;
    l = (v + S / 2 + 8 * S) / S - 8;
    if (l > 2)  l = 2;
    if (l < -2) l = -2;
    e = v - l * S;
    if (e > S)  e = S;
    if (e < -S) e = -S;
    return l;
  endfunction

  task automatic model_edge(input bit rst, en, vld, input int i, q, s, c);
    int   e, lvl;
    bit   acc;
    smp_t in_s;
    in_s = '{i, q};
    if (rst) begin
      mix_q = '{0, 0, 0};
      hold_q.delete();
      cur = '{0, 0};
      m_err = 0; m_code = 2; phase = 0;
      m_run = 0; m_starved = 0; m_underrun = 0;
    end else begin
      lvl    = quant(mix_q.pop_front() + m_err, e);
      m_err  = e;
      m_code = lvl + 2;
      acc    = vld && (hold_q.size() == 0);
      if (!en) begin
        m_run = 0; m_starved = 0; phase = 0;
        hold_q.delete();
        cur = '{0, 0};
      end else if (!m_run) begin
        if (acc) begin
          m_run = 1; m_starved = 0; cur = in_s;
        end
      end else if (phase == RD - 1) begin
        phase = 0;
        if (hold_q.size() > 0) begin
          cur = hold_q.pop_front(); m_starved = 0;
        end else if (acc) begin
          cur = in_s; m_starved = 0;
        end else begin
          cur = '{0, 0}; m_starved = 1; m_underrun = 1;
        end
      end else begin
        phase++;
        if (acc) hold_q.push_back(in_s);
      end
      mix_q.push_back(cur.i * c - cur.q * s);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, en, vld, input int i, q, s, c);
    int st;
    RST = rst; EN = en; IQ_valid = vld;
    I_in = BITS'(i); Q_in = BITS'(q); sin_in = BITS'(s); cos_in = BITS'(c);
    pre_rdy = IQ_ready;
    pre_acc = IQ_valid && IQ_ready;
    @(posedge CLK);
    model_edge(rst, en, vld, i, q, s, c);
    @(negedge CLK);
    st = !m_run ? 0 : (m_starved ? 2 : 1);
    chk("rf_code",  8'(RF_code),  8'(m_code));
    chk("rf_out",   8'(RF_out),   8'(m_code >= 2));
    chk("iq_ready", 8'(IQ_ready), 8'(hold_q.size() == 0));
    chk("underrun", 8'(UNDERRUN), 8'(m_underrun));
    chk("state",    8'(STATE),    8'(st));
  endtask

  function automatic int rs();
    return int'($urandom_range(0, 63)) - 32;
  endfunction

  initial begin
    int sum, oor, accs, rdy_low, n_acc, off2;
    RST = 1'b1; EN = 1'b0; IQ_valid = 1'b0;
    I_in = '0; Q_in = '0; sin_in = '0; cos_in = '0;
    pre_acc = 1'b0; pre_rdy = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of activity
    for (int k = 0; k < 30; k++) step(0, 1, 1, 20, -13, rs(), rs());
    step(1, 1, 1, 20, -13, rs(), rs());
    chk("t1_code",  8'(RF_code),  8'd2);
    chk("t1_ready", 8'(IQ_ready), 8'd1);
    chk("t1_under", 8'(UNDERRUN), 8'd0);
    chk("t1_state", 8'(STATE),    8'd0);

    // Sample arriving on the strobe cycle with an empty holding reg
    step(0, 1, 1, 11, -7, 25, -9);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 25, -9);
    step(0, 1, 1, -17, 9, 25, -9);
    chk("t5_under", 8'(UNDERRUN), 8'd0);
    chk("t5_state", 8'(STATE),    8'd1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, rs(), rs());

    // Disable while running
    step(0, 0, 0, 0, 0, rs(), rs());
    chk("t6_state", 8'(STATE),    8'd0);
    chk("t6_ready", 8'(IQ_ready), 8'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, rs(), rs());
    chk("t6_code", 8'(RF_code), 8'd2);

    // Full-scale DC tone: density of shaped levels
    for (int k = 0; k < 8; k++) step(0, 1, 1, 31, 0, 0, 31);
    sum = 0; oor = 0;
    for (int k = 0; k < 1024; k++) begin
      step(0, 1, 1, 31, 0, 0, 31);
      sum += int'(RF_code) - 2;
      if (RF_code < 3'd2 || RF_code > 3'd4) oor++;
    end
    chk("t2_sum_lo", 8'(sum >= 960), 8'd1);
    chk("t2_sum_hi", 8'(sum <= 962), 8'd1);
    chk("t2_range",  8'(oor),        8'd0);

    // Acceptance rate with valid held high
    accs = 0; rdy_low = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 1, rs(), rs(), rs(), rs());
      if (pre_acc)  accs++;
      if (!pre_rdy) rdy_low++;
    end
    chk("t3_accepts", 8'(accs),    8'd4);
    chk("t3_rdy_low", 8'(rdy_low), 8'd12);
    chk("t3_state",   8'(STATE),   8'd1);

    // Starve after three more samples
    n_acc = 0;
    for (int k = 0; k < 40 && n_acc < 3; k++) begin
      step(0, 1, 1, rs(), rs(), rs(), rs());
      if (pre_acc) n_acc++;
    end
    chk("t4_fed", 8'(n_acc), 8'd3);
    for (int k = 0; k < 12; k++) step(0, 1, 0, 0, 0, rs(), rs());
    chk("t4_under", 8'(UNDERRUN), 8'd1);
    chk("t4_state", 8'(STATE),    8'd2);
    off2 = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0, 0, 0, rs(), rs());
      if (k >= 24 && RF_code != 3'd2) off2++;
    end
    chk("t4_idle_code", 8'(off2), 8'd0);

    // Random traffic with occasional resets and enable drops
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0, rs(), rs(), rs(), rs());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
